// File: rtl/matriz_pkg.sv
// matriz_streamer shared types and defaults.
// Matrix geometry and the scan FSM state encoding.
package matriz_pkg;

    localparam int DIM = 8;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        FIN
    } state_t;

endpackage

// File: rtl/matriz_streamer_if.sv
// Matrix read port plus valid/ready output stream.
// master = streamer side, slave = memory/consumer side.
interface matriz_streamer_if #(
    parameter int DIM = matriz_pkg::DIM,
    parameter int DATA_W = matriz_pkg::DATA_W
);

    localparam int AW = $clog2(DIM);

    logic              rd_en;
    logic [AW-1:0]     rd_row;
    logic [AW-1:0]     rd_col;
    logic [DATA_W-1:0] rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [AW-1:0]     out_row;
    logic [AW-1:0]     out_col;
    logic              out_last;

    modport master (
        output rd_en, rd_row, rd_col,
        input  rd_data,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_row, rd_col,
        output rd_data,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );

endinterface

// File: rtl/matriz_addr_counter.sv
// Row-major (row, col) address walker.
// col runs fastest; last flags cell (DIM-1, DIM-1).
module matriz_addr_counter #(
    parameter int DIM = matriz_pkg::DIM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    output logic [$clog2(DIM)-1:0] row,
    output logic [$clog2(DIM)-1:0] col,
    output logic                   last
);

    localparam int AW = $clog2(DIM);
    localparam logic [AW-1:0] MAX = AW'(DIM - 1);

    // step col, wrapping into the next row
    always_ff @(posedge clk) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == MAX) begin
                col <= '0;
                row <= (row == MAX) ? '0 : row + AW'(1);
            end else begin
                col <= col + AW'(1);
            end
        end
    end

    assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/matriz_streamer.sv
// Scans a DIM x DIM matrix cell by cell and streams
// each value with its address over a valid/ready port.
module matriz_streamer #(
    parameter int DIM = matriz_pkg::DIM,
    parameter int DATA_W = matriz_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    matriz_streamer_if.master              bus,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(DIM*DIM+1)-1:0]   nz_count
);

    import matriz_pkg::*;

    localparam int AW = $clog2(DIM);
    localparam int NW = $clog2(DIM * DIM + 1);
    localparam logic [AW-1:0] MAX = AW'(DIM - 1);

    state_t state;
    state_t state_nx;

    logic clear;
    logic advance;
    logic load;

    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          last;

    logic [DATA_W-1:0] data_q;
    logic [AW-1:0]     row_q;
    logic [AW-1:0]     col_q;
    logic [NW-1:0]     nz_q;

    matriz_addr_counter #(
        .DIM(DIM)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .advance(advance),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and per-cycle strobes
    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear    = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                state_nx = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (last) begin
                        state_nx = FIN;
                    end else begin
                        advance  = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // beat payload capture and nonzero tally
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            nz_q   <= '0;
        end else begin
            if (clear) begin
                nz_q <= '0;
            end
            if (load) begin
                data_q <= bus.rd_data;
                row_q  <= row;
                col_q  <= col;
                if (bus.rd_data != '0) begin
                    nz_q <= nz_q + NW'(1);
                end
            end
        end
    end

    assign bus.rd_en     = (state == FETCH);
    assign bus.rd_row    = row;
    assign bus.rd_col    = col;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = data_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = (state == SEND)
                         && (row_q == MAX)
                         && (col_q == MAX);

    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign nz_count = nz_q;

endmodule

// File: doc/matriz_streamer.md
MATRIZ_STREAMER -- requirements
Module: matriz_streamer

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning the matrix is DIM x DIM cells.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the cell width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a full matrix scan.
REQ-006 SHALL have port rd_en, output, 1 bit: matrix read strobe.
REQ-007 SHALL have ports rd_row and rd_col, output, $clog2(DIM) bits each: read address.
REQ-008 SHALL have port rd_data, input, DATA_W bits: cell value, valid exactly 1 cycle after rd_en.
REQ-009 SHALL have port out_valid, output, 1 bit: the stream beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-011 SHALL have ports out_data (DATA_W bits), out_row and out_col ($clog2(DIM) bits each), output: beat payload.
REQ-012 SHALL have port out_last, output, 1 bit: the beat is cell (DIM-1, DIM-1).
REQ-013 SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a scan ends.
REQ-015 SHALL have port nz_count, output, $clog2(DIM*DIM+1) bits: count of nonzero cells in the last or current scan.

Function
REQ-016 SHALL implement an FSM with the states IDLE, FETCH, LOAD, SEND and FIN.
REQ-017 IDLE: a start of 1 SHALL clear nz_count, set the address to (0,0) and go to FETCH next cycle.
REQ-018 FETCH: SHALL assert rd_en for exactly one cycle with the current rd_row/rd_col, then go to LOAD.
REQ-019 LOAD: SHALL capture rd_data plus its row/col into the output registers, increment nz_count if rd_data != 0, and go to SEND.
REQ-020 SEND: SHALL hold out_valid=1 with a stable payload until out_valid and out_ready are both 1 in the same cycle.
REQ-021 On the handshake in SEND: if the beat is not the last, SHALL advance the address and go to FETCH; else SHALL go to FIN.
REQ-022 Address order SHALL be row-major: col increments first; at col=DIM-1, col wraps to 0 and row increments.
REQ-023 FIN: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-024 out_last SHALL be 1 only while out_valid=1 and the payload address is (DIM-1, DIM-1).
REQ-025 busy SHALL be 1 in FETCH, LOAD, SEND and FIN, and 0 in IDLE.
REQ-026 start SHALL be ignored while busy=1, including start asserted in the FIN cycle.
REQ-027 Minimum latency SHALL be 3 cycles per cell: start to first out_valid is 3 cycles, and a full scan with out_ready held at 1 is DIM*DIM*3+1 cycles from start to done.
REQ-028 out_ready asserted outside SEND SHALL have no effect.
REQ-029 nz_count SHALL saturate-free count to a maximum of DIM*DIM and hold its value after done until the next accepted start.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, and SHALL set every output (rd_en, rd_row, rd_col, out_valid, out_data, out_row, out_col, out_last, busy, done, nz_count) to 0.
REQ-031 reset during any active state SHALL abort the scan with no done pulse; the next scan SHALL restart at (0,0).

Structure
REQ-032 A shared package matriz_pkg SHALL hold DIM, DATA_W and the state enum type.
REQ-033 The row/column address counter with wrap and last detection SHALL be a sub-module named matriz_addr_counter.

Verification
REQ-034 Matrix all 0 except 0x123 at (1,2) and 0x456 at (3,4), out_ready=1, one start -> 64 beats in row-major order with the correct values; out_last only on (7,7); done once; nz_count=2.
REQ-035 out_ready toggled pseudo-randomly with 0 for up to 5 cycles -> payload is stable while stalled; no beats are lost or duplicated.
REQ-036 start asserted again in the middle of a scan and in the FIN cycle -> ignored; exactly one done pulse.
REQ-037 reset=0 while in SEND at cell (3,4) -> all outputs 0 on the next cycle; a new start streams again from (0,0).
REQ-038 All 64 cells = 0xFFFFFFFF -> nz_count=64; start to done = 193 cycles with out_ready=1.
